// File: rtl/multi_in_filter_if.sv
// Pin-side bundle of the multi-channel input filter: raw pins and bypass in,
// filtered levels and edge strobes out.
interface multi_in_filter_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] pin;
  logic [CHANNELS-1:0] bypass;
  logic [CHANNELS-1:0] rd;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  modport master (output pin, output bypass, input rd, input rise, input fall);
  modport slave  (input pin, input bypass, output rd, output rise, output fall);
endinterface

// File: rtl/multi_in_filter.sv
// Per-channel synchroniser, saturating up/down glitch counter and Schmitt-trigger
// thresholds with optional bypass; emits the filtered level plus rise/fall strobes.
module multi_in_filter #(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 3,
  parameter int FILTERBITS  = 5,
  parameter int SET_LEVEL   = 24,
  parameter int CLR_LEVEL   = 7,
  parameter int RESET_VALUE = 0
) (
  input  logic               clk,
  input  logic               rst,
  multi_in_filter_if.slave   io
);

  if (CHANNELS < 1 || SYNC_STAGES < 2 || FILTERBITS < 3 || CLR_LEVEL < 0 ||
      CLR_LEVEL >= SET_LEVEL || SET_LEVEL > (1 << FILTERBITS) - 1 ||
      (RESET_VALUE != 0 && RESET_VALUE != 1)) begin : g_param_err
    $error("multi_in_filter: illegal parameter combination");
  end

  localparam logic                  RV      = (RESET_VALUE != 0);
  localparam logic [FILTERBITS-1:0] CNT_MAX = {FILTERBITS{1'b1}};
  localparam logic [FILTERBITS-1:0] CNT_RST = RV ? CNT_MAX : '0;
  localparam logic [FILTERBITS-1:0] SET_L   = FILTERBITS'(SET_LEVEL);
  localparam logic [FILTERBITS-1:0] CLR_L   = FILTERBITS'(CLR_LEVEL);

  logic [CHANNELS-1:0] rd_v;
  logic [CHANNELS-1:0] rise_v;
  logic [CHANNELS-1:0] fall_v;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILTERBITS-1:0]  cnt_q, cnt_d;
    logic                   rd_q, rd_d;
    logic                   rise_q, fall_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      cnt_d = cnt_q;
      if (s && cnt_q != CNT_MAX)
        cnt_d = cnt_q + FILTERBITS'(1);
      else if (!s && cnt_q != '0)
        cnt_d = cnt_q - FILTERBITS'(1);
    end

    // Thresholds act on the current count, so rd trails the counter by one edge.
    always_comb begin
      rd_d = rd_q;
      if (io.bypass[c])
        rd_d = s;
      else if (cnt_q >= SET_L)
        rd_d = 1'b1;
      else if (cnt_q <= CLR_L)
        rd_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= {SYNC_STAGES{RV}};
        cnt_q  <= CNT_RST;
        rd_q   <= RV;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], io.pin[c]};
        cnt_q  <= cnt_d;
        rd_q   <= rd_d;
        rise_q <= rd_d & ~rd_q;
        fall_q <= ~rd_d & rd_q;
      end
    end

    assign rd_v[c]   = rd_q;
    assign rise_v[c] = rise_q;
    assign fall_v[c] = fall_q;
  end

  assign io.rd   = rd_v;
  assign io.rise = rise_v;
  assign io.fall = fall_v;

endmodule

// File: tb/tb_multi_in_filter.sv
// Scoreboard bench for multi_in_filter: three builds (default, RESET_VALUE=1,
// narrow 3-bit counter) driven in lockstep against a behavioural channel model.
module tb_multi_in_filter;

  logic clk;
  logic rst;

  multi_in_filter_if #(.CHANNELS(8)) ifa ();
  multi_in_filter_if #(.CHANNELS(2)) ifb ();
  multi_in_filter_if #(.CHANNELS(1)) ifc ();

  multi_in_filter #(.CHANNELS(8)) u_dut_a (.clk(clk), .rst(rst), .io(ifa));
  multi_in_filter #(.CHANNELS(2), .RESET_VALUE(1)) u_dut_b (.clk(clk), .rst(rst), .io(ifb));
  multi_in_filter #(.CHANNELS(1), .FILTERBITS(3), .SET_LEVEL(6), .CLR_LEVEL(1))
    u_dut_c (.clk(clk), .rst(rst), .io(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sh;
    int         cnt;
    logic       rd;
    logic       rise;
    logic       fall;
  } ch_t;

  ch_t ma[8];
  ch_t mb[2];
  ch_t mc;

  logic [23:0] qa[$];
  logic [5:0]  qb[$];
  logic [2:0]  qc[$];

  int n_vec    = 0;
  int n_miscmp = 0;
  int a_rise[8];
  int a_fall[8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic ch_t rst_state(input logic rv, input int maxv);
    ch_t n;
    n.sh   = rv ? 8'hFF : 8'h00;
    n.cnt  = rv ? maxv : 0;
    n.rd   = rv;
    n.rise = 1'b0;
    n.fall = 1'b0;
    return n;
  endfunction

  // One clock edge of a channel as seen from outside: shift, count, threshold.
  function automatic ch_t step(input ch_t st, input logic p, input logic byp,
                               input int stages, input int maxv, input int setl, input int clrl);
    ch_t  n;
    logic s;
    n = st;
    s = st.sh[stages-1];
    n.sh = {st.sh[6:0], p};
    if (s && st.cnt < maxv) n.cnt = st.cnt + 1;
    else if (!s && st.cnt > 0) n.cnt = st.cnt - 1;
    if (byp) n.rd = s;
    else if (st.cnt >= setl) n.rd = 1'b1;
    else if (st.cnt <= clrl) n.rd = 1'b0;
    n.rise = n.rd & ~st.rd;
    n.fall = ~n.rd & st.rd;
    return n;
  endfunction

  task automatic clr_stats();
    for (int c = 0; c < 8; c++) begin
      a_rise[c] = 0;
      a_fall[c] = 0;
    end
  endtask

  // Inputs are stable here; predict the next edge, push, then compare after it.
  task automatic cycle();
    logic [23:0] ea;
    logic [5:0]  eb;
    logic [2:0]  ec;
    ifc.pin[0] = 1'($urandom_range(0, 1));
    ea = '0;
    eb = '0;
    for (int c = 0; c < 8; c++) begin
      ma[c] = step(ma[c], ifa.pin[c], ifa.bypass[c], 3, 31, 24, 7);
      ea[16+c] = ma[c].rd; ea[8+c] = ma[c].rise; ea[c] = ma[c].fall;
    end
    for (int c = 0; c < 2; c++) begin
      mb[c] = step(mb[c], ifb.pin[c], ifb.bypass[c], 3, 31, 24, 7);
      eb[4+c] = mb[c].rd; eb[2+c] = mb[c].rise; eb[c] = mb[c].fall;
    end
    mc = step(mc, ifc.pin[0], ifc.bypass[0], 3, 7, 6, 1);
    ec = {mc.rd, mc.rise, mc.fall};
    qa.push_back(ea);
    qb.push_back(eb);
    qc.push_back(ec);
    @(posedge clk);
    #1;
    check_eq("sb_a", 32'({ifa.rd, ifa.rise, ifa.fall}), 32'(qa.pop_front()));
    check_eq("sb_b", 32'({ifb.rd, ifb.rise, ifb.fall}), 32'(qb.pop_front()));
    check_eq("sb_c", 32'({ifc.rd, ifc.rise, ifc.fall}), 32'(qc.pop_front()));
    for (int c = 0; c < 8; c++) begin
      a_rise[c] += int'(ifa.rise[c]);
      a_fall[c] += int'(ifa.fall[c]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) ma[c] = rst_state(1'b0, 31);
    for (int c = 0; c < 2; c++) mb[c] = rst_state(1'b1, 31);
    mc = rst_state(1'b0, 7);
    check_eq("rst_rd_a",   32'(ifa.rd), 32'h00);
    check_eq("rst_strb_a", 32'({ifa.rise, ifa.fall}), 32'h0);
    check_eq("rst_rd_b",   32'(ifb.rd), 32'h3);
    check_eq("rst_strb_b", 32'({ifb.rise, ifb.fall}), 32'h0);
    check_eq("rst_rd_c",   32'(ifc.rd), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // pin[0] is already high; rd[0] must rise at edge 28 and build B must fall at 28.
  task automatic rise_after_reset(input string tag);
    int   first_a, first_b, brise, oth;
    logic rise_at_first;
    first_a = -1; first_b = -1; brise = 0; oth = 0; rise_at_first = 1'b0;
    clr_stats();
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (ifa.rd[0] && first_a < 0) begin
        first_a = i;
        rise_at_first = ifa.rise[0];
      end
      if (ifb.rd == 2'b00 && first_b < 0) first_b = i;
      brise += int'(|ifb.rise);
      oth |= int'(|ifa.rd[7:1]);
    end
    check_eq({tag, "_rise_edge"}, 32'(first_a), 32'd28);
    check_eq({tag, "_rise_strobe"}, 32'(rise_at_first), 32'd1);
    check_eq({tag, "_rise_count"}, 32'(a_rise[0]), 32'd1);
    check_eq({tag, "_no_fall"}, 32'(a_fall[0]), 32'd0);
    check_eq({tag, "_others_low"}, 32'(oth), 32'd0);
    check_eq({tag, "_b_fall_edge"}, 32'(first_b), 32'd28);
    check_eq({tag, "_b_no_rise"}, 32'(brise), 32'd0);
  endtask

  initial begin
    int first, ok;
    rst = 1'b1;
    ifa.pin = '0; ifa.bypass = '0;
    ifb.pin = '0; ifb.bypass = '0;
    ifc.pin = '0; ifc.bypass = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Rise latency from count 0
    ifa.pin[0] = 1'b1;
    rise_after_reset("t1");

    // Fall latency from saturated high, then stay at 0 without a second strobe
    ifa.pin[0] = 1'b0;
    clr_stats();
    first = -1;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (!ifa.rd[0] && first < 0) first = i;
    end
    check_eq("t2_fall_edge", 32'(first), 32'd28);
    check_eq("t2_fall_count", 32'(a_fall[0]), 32'd1);
    check_eq("t2_no_rise", 32'(a_rise[0]), 32'd0);

    // Short glitches never reach SET_LEVEL
    clr_stats();
    for (int p = 0; p < 5; p++) begin
      ifa.pin[1] = 1'b1; repeat (10) cycle();
      ifa.pin[1] = 1'b0; repeat (10) cycle();
    end
    check_eq("t3_glitch_rise", 32'(a_rise[1]), 32'd0);
    check_eq("t3_glitch_rd", 32'(ifa.rd[1]), 32'd0);
    for (int p = 0; p < 4; p++) begin
      ifa.pin[1] = 1'b1; repeat (20) cycle();
      ifa.pin[1] = 1'b0; repeat (2) cycle();
    end
    check_eq("t3_climb_rise", 32'(a_rise[1]), 32'd1);
    check_eq("t3_no_chatter", 32'(a_fall[1]), 32'd0);
    check_eq("t3_climb_rd", 32'(ifa.rd[1]), 32'd1);

    // Bypass follows the synchronised pin with a 4-edge lag
    clr_stats();
    ifa.bypass[3] = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (i % 8 == 0) ifa.pin[3] = ~ifa.pin[3];
      cycle();
      if (ifa.rise[3] || ifa.fall[3]) check_eq("t4_byp_lag", 32'(i % 8), 32'd3);
    end
    check_eq("t4_byp_rises", 32'(a_rise[3]), 32'd3);
    check_eq("t4_byp_falls", 32'(a_fall[3]), 32'd3);
    ifa.pin[3] = 1'b1;
    repeat (20) cycle();
    check_eq("t4_byp_high", 32'(ifa.rd[3]), 32'd1);
    ifa.bypass[3] = 1'b0;
    clr_stats();
    repeat (5) cycle();
    check_eq("t4_drop_hold", 32'(ifa.rd[3]), 32'd1);
    ifa.pin[3] = 1'b0;
    first = -1;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (ifa.fall[3] && first < 0) first = i;
    end
    ok = int'(first >= 12 && first <= 40);
    check_eq("t4_drop_fall_window", 32'(ok), 32'd1);
    check_eq("t4_drop_one_fall", 32'(a_fall[3]), 32'd1);
    check_eq("t4_drop_no_rise", 32'(a_rise[3]), 32'd0);

    // Reset in the middle of a count: latency must start over from zero
    ifa.pin[0] = 1'b1;
    repeat (23) cycle();
    check_eq("t5_mid_rd", 32'(ifa.rd[0]), 32'd0);
    #2;
    do_reset();
    rise_after_reset("t5");

    // Random soak on all builds
    for (int i = 0; i < 20000; i++) begin
      ifa.pin = 8'($urandom);
      ifb.pin = 2'($urandom);
      if ($urandom_range(0, 63) == 0) ifa.bypass = 8'($urandom);
      if ($urandom_range(0, 63) == 0) ifc.bypass[0] = ~ifc.bypass[0];
      if ($urandom_range(0, 3) != 0) ifa.pin = ifa.pin & 8'h0F | {4{ifa.pin[0]}} << 4;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
